// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: HI/LO unit op encodings,
// default multiply/divide latencies and the unit's FSM state type.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO multiply/divide unit. The arithmetic result is computed
// combinationally when an op is accepted and parked in pending registers;
// a down-counter then models the multi-cycle latency before HI/LO update.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_clr,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  md_op_e    op;
  md_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        busy_q, busy_d;

  logic        is_start, is_mul;
  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic [63:0] prod_u;
  logic        div_zero, div_ovf;
  logic signed [31:0] rs_s, rt_s_safe, quot_s, rem_s;
  logic [31:0] rt_u_safe, quot_u, rem_u;
  logic [31:0] res_hi, res_lo;

  assign op       = md_op_e'(md_op);
  assign is_start = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign is_mul   = (op == MD_MULT) || (op == MD_MULTU);

  // Products: sign- or zero-extend to 64 bits so the full result is kept.
  assign rs_sx  = {{32{rs_in[31]}}, rs_in};
  assign rt_sx  = {{32{rt_in[31]}}, rt_in};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'b0, rs_in} * {32'b0, rt_in};

  // Zero divisor and MIN/-1 are replaced by a divisor of 1 so the divider never
  // sees an undefined case; their architectural results are muxed in below.
  assign div_zero  = (rt_in == 32'h0);
  assign div_ovf   = (rs_in == 32'h8000_0000) && (rt_in == 32'hFFFF_FFFF);
  assign rs_s      = rs_in;
  assign rt_s_safe = (div_zero || div_ovf) ? 32'sd1 : rt_in;
  assign quot_s    = rs_s / rt_s_safe;
  assign rem_s     = rs_s % rt_s_safe;
  assign rt_u_safe = div_zero ? 32'd1 : rt_in;
  assign quot_u    = rs_in / rt_u_safe;
  assign rem_u     = rs_in % rt_u_safe;

  // Select the HI/LO result for the op being offered this cycle.
  always_comb begin
    res_hi = 32'h0;
    res_lo = 32'h0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (div_zero) begin
          res_hi = rs_in;
          res_lo = rs_in[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'h0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          res_hi = rs_in;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: begin
        res_hi = 32'h0;
        res_lo = 32'h0;
      end
    endcase
  end

  // Next-state logic: accept starts and MTHI/MTLO only when idle and not
  // flushed; while busy, ignore md_op entirely and count down to write-back.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      MD_IDLE: begin
        if (!int_clr) begin
          if (is_start) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            count_d   = is_mul ? MULT_LOAD : DIV_LOAD;
            state_d   = MD_BUSY;
          end else if (op == MD_MTHI) begin
            hi_d = rs_in;
          end else if (op == MD_MTLO) begin
            lo_d = rs_in;
          end
        end
      end
      MD_BUSY: begin
        if (count_q <= CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          count_d = '0;
          state_d = MD_IDLE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (state_d == MD_BUSY);
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      count_q   <= '0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and busy
// length for each accepted start; a monitor pops on every falling busy.
module tb_muldiv_unit;
  import mips_pkg::*;

  localparam int N_MULT = MD_MULT_CYCLES;
  localparam int N_DIV  = MD_DIV_CYCLES;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        int_clr = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_in = 32'h0;
  logic [31:0] rt_in = 32'h0;
  logic        busy;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passes = 0;
  int          model_left = 0;
  logic [31:0] model_hi = 32'h0, model_lo = 32'h0;
  logic [31:0] pend_hi = 32'h0, pend_lo = 32'h0;
  bit          abort_pending = 1'b0;

  muldiv_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk(clk), .reset(reset), .int_clr(int_clr), .md_op(md_op),
    .rs_in(rs_in), .rt_in(rt_in), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural reference: {HI,LO} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      1: begin q = sa * sb; return q; end
      2: begin u = {32'b0, a} * {32'b0, b}; return u; end
      3: begin
        if (b == 0) return {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    if (model_left > 0) begin
      model_left--;
      if (model_left == 0) begin
        model_hi = pend_hi;
        model_lo = pend_lo;
      end
    end
  endtask

  task automatic apply_stimulus(input int op, input logic [31:0] a, input logic [31:0] b, input bit clr);
    logic [63:0] r;
    int n;
    md_op = 3'(op);
    rs_in = a;
    rt_in = b;
    int_clr = clr;
    if (model_left == 0 && !clr) begin
      if (op >= 1 && op <= 4) begin
        r = ref_result(op, a, b);
        n = (op <= 2) ? N_MULT : N_DIV;
        pend_hi = r[63:32];
        pend_lo = r[31:0];
        model_left = n + 1;
        sb_q.push_back('{hi: r[63:32], lo: r[31:0], cycles: n});
      end else if (op == 5) begin
        model_hi = a;
      end else if (op == 6) begin
        model_lo = a;
      end
    end
    step();
    md_op = 3'd0;
    int_clr = 1'b0;
    rs_in = $urandom;
    rt_in = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && model_left > 0; i++) step();
  endtask

  task automatic check_output(input string tag);
    compare({tag, ".busy"}, {31'b0, busy}, (model_left > 0) ? 32'd1 : 32'd0);
    compare({tag, ".hi"}, hi_out, model_hi);
    compare({tag, ".lo"}, lo_out, model_lo);
  endtask

  // Monitor: count busy cycles and score each completed operation.
  initial begin
    int  busy_cnt;
    bit  prev_busy;
    exp_t e;
    busy_cnt = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          compare("mon.cycles", busy_cnt, e.cycles);
          compare("mon.hi", hi_out, e.hi);
          compare("mon.lo", lo_out, e.lo);
        end else if (abort_pending) begin
          abort_pending = 1'b0;
        end else begin
          checks++;
          $display("[TB] FAIL mon.unexpected_done: got busy fall expected none");
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // Directed plan followed by randomized ops against the reference model.
  initial begin
    int op, sel;
    logic [31:0] a, b;
    bit clr;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_output("reset");

    apply_stimulus(1, 32'hFFFF_FFFE, 32'd3, 0);
    wait_idle();
    check_output("mult_neg");
    compare("mult_neg.lo_const", lo_out, 32'hFFFF_FFFA);

    apply_stimulus(2, 32'hFFFF_FFFF, 32'd2, 0);
    wait_idle();
    check_output("multu");

    apply_stimulus(3, 32'hFFFF_FFF9, 32'd2, 0);
    wait_idle();
    check_output("div_neg");

    apply_stimulus(4, 32'd5, 32'd0, 0);
    wait_idle();
    check_output("divu_zero");

    apply_stimulus(3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_idle();
    check_output("div_ovf");

    apply_stimulus(5, 32'h1234_5678, 32'h0, 0);
    check_output("mthi");

    apply_stimulus(6, 32'hCAFE_F00D, 32'h0, 1);
    check_output("mtlo_clr");

    apply_stimulus(1, 32'd9, 32'd9, 1);
    check_output("mult_clr");

    apply_stimulus(3, 32'd100, 32'd7, 0);
    step();
    apply_stimulus(1, 32'd3, 32'd4, 0);
    apply_stimulus(6, 32'hDEAD_BEEF, 32'h0, 0);
    apply_stimulus(0, 32'h0, 32'h0, 1);
    wait_idle();
    check_output("div_ignore");

    for (int i = 0; i < 30; i++) begin
      op  = int'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'h0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      clr = ($urandom_range(0, 7) == 0);
      apply_stimulus(op, a, b, clr);
      wait_idle();
      check_output("rand");
    end

    apply_stimulus(1, 32'd7, 32'd9, 0);
    step();
    step();
    sb_q.delete();
    abort_pending = 1'b1;
    model_left = 0;
    model_hi = 32'h0;
    model_lo = 32'h0;
    reset = 1'b1;
    step();
    check_output("reset_mid");
    reset = 1'b0;
    repeat (N_MULT + 3) step();
    check_output("reset_after");

    compare("sb.empty", sb_q.size(), 32'd0);
    compare("abort.seen", {31'b0, abort_pending}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- EX-stage HI/LO multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs: operand values RS_E and RT_E, plus a decoded md_op derived from IR_E.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and MTHI/MTLO in one cycle.
- Holds the architectural HI/LO registers and exports busy to the hazard unit, which stalls MFHI/MFLO/MD instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (must be >=1).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- int_clr  in  1  exception/interrupt flush of the instruction currently in EX
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- rs_in  in  32  forwarded RS operand
- rt_in  in  32  forwarded RT operand
- busy  out  1  registered; high while an operation is in flight
- hi_out  out  32  architectural HI, registered
- lo_out  out  32  architectural LO, registered

Behaviour:
- Reset (sampled at posedge): HI=0, LO=0, busy=0, counter=0, state=IDLE. Reset mid-operation aborts it and discards the pending result.
- States:
  - IDLE -> BUSY on accepted start.
  - BUSY -> IDLE when the counter reaches 1 at a posedge.
- Accept rule, at a posedge where state=IDLE, md_op in 1..4, and int_clr=0:
  - capture the result into pending_hi/pending_lo;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - set busy=1.
- Timing for a start accepted at edge t:
  - busy=1 for exactly N cycles, i.e. edges t+1..t+N each decrement the counter.
  - At edge t+N: HI/LO take the pending values and busy returns to 0 in the same edge.
  - The result is visible on hi_out/lo_out in the cycle after busy falls.
  - The hazard unit treats (md_op start | busy) as occupied.
- MULT: {HI,LO} = signed rs * signed rt (64-bit). MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero, with no X permitted:
  - DIVU: LO=32'hFFFFFFFF, HI=rs.
  - DIV: LO=(rs[31]?32'h00000001:32'hFFFFFFFF), HI=rs.
- DIV overflow (rs=32'h80000000, rt=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- MTHI/MTLO: in IDLE with int_clr=0, HI (or LO) <= rs_in at that edge. busy is not asserted.
- While busy, every md_op is ignored, including MTHI/MTLO and new starts. The hazard unit guarantees none arrive; the unit does not queue them.
- int_clr=1 in the same cycle as any md_op: the op is suppressed and HI/LO are unchanged.
- int_clr during BUSY: no effect. The in-flight op was issued by an older, committed instruction and completes normally.
- Counter width is sized from max(MULT_CYCLES, DIV_CYCLES). No wrap-around: the counter never decrements below 1 in BUSY.
- Operands are captured at accept; later rs_in/rt_in changes do not affect the pending result.

Decomposition:
- Shared package (mips_pkg): md_op encodings (MD_NONE..MD_MTLO), default latency constants MD_MULT_CYCLES=5 and MD_DIV_CYCLES=10.
- No sub-module. The product and quotient are computed combinationally at accept, and the counter models latency. A separate iterative divider is out of scope for this block.

Test Plan:
- Reset, then MULT rs=32'hFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
- MULTU rs=32'hFFFFFFFF, rt=2 -> HI=1, LO=32'hFFFFFFFE. DIV rs=-7, rt=2 -> busy 10 cycles; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU rs=5, rt=0 -> LO=32'hFFFFFFFF, HI=5. DIV rs=32'h80000000, rt=-1 -> LO=32'h80000000, HI=0.
- MTHI rs=32'h12345678 in IDLE -> HI updates the next cycle and busy stays 0. MTLO with int_clr=1 -> LO unchanged.
- During DIV busy: drive MULT and MTLO each for one cycle -> both ignored, DIV result is unaffected. int_clr pulse mid-DIV -> DIV still completes.
- Assert reset at busy cycle 3 of MULT -> next cycle busy=0, HI=LO=0, and no late write-back occurs.
